// File: rtl/regfile_wb_arbiter_pkg.sv
// regfile_ctrl_pkg: shared register constants and the pending writeback entry type
package regfile_ctrl_pkg;
  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam logic [4:0] REG_RSTATUS = 5'd30;
  localparam logic [31:0] EXC_DATA = 32'h0000_0001;
  typedef struct packed {
    logic [4:0] rd;
    logic [31:0] data;
    logic kill;
  } wb_entry_t;
endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// regfile_wb_arbiter_if: ALU/multdiv writeback requests and register-file write port
interface regfile_wb_arbiter_if;
  logic alu_wb_valid;
  logic [4:0] alu_wb_reg;
  logic [31:0] alu_wb_data;
  logic md_wb_valid;
  logic md_wb_ready;
  logic [4:0] md_wb_reg;
  logic [31:0] md_wb_data;
  logic md_wb_exc;
  logic ctrl_writeEnable;
  logic [4:0] ctrl_writeReg;
  logic [31:0] data_writeReg;
  logic wb_stall;
  logic [2:0] pend_count;
  modport master (
    output alu_wb_valid, alu_wb_reg, alu_wb_data, md_wb_valid, md_wb_reg, md_wb_data, md_wb_exc,
    input md_wb_ready, ctrl_writeEnable, ctrl_writeReg, data_writeReg, wb_stall, pend_count
  );
  modport slave (
    input alu_wb_valid, alu_wb_reg, alu_wb_data, md_wb_valid, md_wb_reg, md_wb_data, md_wb_exc,
    output md_wb_ready, ctrl_writeEnable, ctrl_writeReg, data_writeReg, wb_stall, pend_count
  );
endinterface

// File: rtl/regfile_wb_arbiter_fifo.sv
// wb_pend_fifo: circular buffer of pending multdiv writebacks with parallel kill-by-register
module wb_pend_fifo
  import regfile_ctrl_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic       clock,
  input  logic       ctrl_reset,
  input  logic       push_i,
  input  wb_entry_t  push_entry_i,
  input  logic       pop_i,
  input  logic       kill_i,
  input  logic [4:0] kill_rd_i,
  output wb_entry_t  head_o,
  output logic [2:0] count_o
);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  wb_entry_t [DEPTH-1:0] mem_q, mem_d;
  logic [PW-1:0] head_q, tail_q;
  logic [2:0] count_q;
  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return p == PW'(DEPTH - 1) ? '0 : p + 1'b1;
  endfunction
  // mark matching entries killed, including the one being written this cycle
  always_comb begin
    mem_d = mem_q;
    for (int i = 0; i < DEPTH; i++)
      if (kill_i && mem_q[i].rd == kill_rd_i) mem_d[i].kill = 1'b1;
    if (push_i) begin
      mem_d[tail_q] = push_entry_i;
      mem_d[tail_q].kill = push_entry_i.kill | (kill_i && push_entry_i.rd == kill_rd_i);
    end
  end
  // storage, pointers and occupancy; reset discards every entry
  always_ff @(posedge clock) begin
    if (ctrl_reset) begin
      mem_q <= '0;
      head_q <= '0;
      tail_q <= '0;
      count_q <= '0;
    end else begin
      mem_q <= mem_d;
      tail_q <= push_i ? inc(tail_q) : tail_q;
      head_q <= pop_i ? inc(head_q) : head_q;
      count_q <= count_q + 3'(push_i) - 3'(pop_i);
    end
  end
  assign head_o = mem_q[head_q];
  assign count_o = count_q;
endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the regfile write port between ALU and multdiv; MD_EXC_EN redirects multdiv exceptions to $rstatus
module regfile_wb_arbiter
  import regfile_ctrl_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int MAX_WAIT = 4
) (
  input logic clock,
  input logic ctrl_reset,
  regfile_wb_arbiter_if.slave wb
);
  wb_entry_t head;
  logic [2:0] count;
  logic empty, alu_req, head_live, grant_md, pop, push, ready;
  logic [4:0] md_rd;
  logic [31:0] md_data;
  logic [3:0] wait_q, wait_d;
  logic stall_q, we_q;
  logic [4:0] rd_q;
  logic [31:0] data_q;
`ifdef MD_EXC_EN
  assign md_rd = wb.md_wb_exc ? REG_RSTATUS : wb.md_wb_reg;
  assign md_data = wb.md_wb_exc ? EXC_DATA : wb.md_wb_data;
`else
  assign md_rd = wb.md_wb_reg;
  assign md_data = wb.md_wb_data;
`endif
  assign empty = count == 3'd0;
  assign alu_req = wb.alu_wb_valid && wb.alu_wb_reg != REG_ZERO;
  assign head_live = !empty && !head.kill;
  assign grant_md = !alu_req && head_live;
  assign pop = !alu_req && !empty;
  assign ready = !ctrl_reset && count < 3'(DEPTH);
  assign push = wb.md_wb_valid && ready && md_rd != REG_ZERO;
  wb_pend_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock(clock),
    .ctrl_reset(ctrl_reset),
    .push_i(push),
    .push_entry_i('{rd: md_rd, data: md_data, kill: 1'b0}),
    .pop_i(pop),
    .kill_i(alu_req),
    .kill_rd_i(wb.alu_wb_reg),
    .head_o(head),
    .count_o(count)
  );
  // count consecutive cycles a live head is passed over, saturating
  always_comb begin
    wait_d = (empty || grant_md) ? 4'd0 : head_live ? (wait_q == 4'hf ? wait_q : wait_q + 4'd1) : wait_q;
  end
  // registered write port and starvation stall
  always_ff @(posedge clock) begin
    if (ctrl_reset) begin
      we_q <= 1'b0;
      rd_q <= '0;
      data_q <= '0;
      wait_q <= '0;
      stall_q <= 1'b0;
    end else begin
      we_q <= alu_req || grant_md;
      rd_q <= alu_req ? wb.alu_wb_reg : grant_md ? head.rd : '0;
      data_q <= alu_req ? wb.alu_wb_data : grant_md ? head.data : '0;
      wait_q <= wait_d;
      stall_q <= wait_d >= 4'(MAX_WAIT);
    end
  end
  assign wb.md_wb_ready = ready;
  assign wb.ctrl_writeEnable = we_q;
  assign wb.ctrl_writeReg = rd_q;
  assign wb.data_writeReg = data_q;
  assign wb.wb_stall = stall_q;
  assign wb.pend_count = count;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed and random writeback traffic checked against a queue model
module tb_regfile_wb_arbiter;
  localparam int DEPTH = 2;
  localparam int MAX_WAIT = 4;
  typedef struct {
    logic [4:0] rd;
    logic [31:0] data;
    bit kill;
  } ent_t;
  logic clock = 1'b0;
  logic ctrl_reset;
  int total = 0;
  int bad = 0;
  int waitc = 0;
  ent_t q[$];
  logic exp_we = 1'b0;
  logic [4:0] exp_rd = '0;
  logic [31:0] exp_data = '0;
  logic exp_stall = 1'b0;
  always #5 clock = ~clock;
  regfile_wb_arbiter_if wb();
  regfile_wb_arbiter #(.DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
    .clock(clock),
    .ctrl_reset(ctrl_reset),
    .wb(wb)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask
  task automatic cyc(input bit r, input bit av, input logic [4:0] ar, input logic [31:0] ad,
                     input bit mv, input logic [4:0] mr, input logic [31:0] md, input bit me);
    bit rdy, alu, ne, live, granted;
    ent_t e;
    logic [4:0] er;
    logic [31:0] ed;
    ctrl_reset = r;
    wb.alu_wb_valid = av;
    wb.alu_wb_reg = ar;
    wb.alu_wb_data = ad;
    wb.md_wb_valid = mv;
    wb.md_wb_reg = mr;
    wb.md_wb_data = md;
    wb.md_wb_exc = me;
    #1;
    rdy = !r && q.size() < DEPTH;
    check("ready", 64'(wb.md_wb_ready), 64'(rdy));
    @(posedge clock);
    er = mr;
    ed = md;
`ifdef MD_EXC_EN
    if (me) begin
      er = 5'd30;
      ed = 32'd1;
    end
`endif
    if (r) begin
      q.delete();
      {exp_we, exp_rd, exp_data, exp_stall} = '0;
      waitc = 0;
    end else begin
      alu = av && ar != 0;
      ne = q.size() > 0;
      live = ne && !q[0].kill;
      granted = 0;
      {exp_we, exp_rd, exp_data} = '0;
      if (alu) begin
        foreach (q[i]) if (q[i].rd == ar) q[i].kill = 1;
        {exp_we, exp_rd, exp_data} = {1'b1, ar, ad};
      end else if (ne) begin
        e = q.pop_front();
        if (!e.kill) begin
          granted = 1;
          {exp_we, exp_rd, exp_data} = {1'b1, e.rd, e.data};
        end
      end
      waitc = (!ne || granted) ? 0 : live ? (waitc < 15 ? waitc + 1 : 15) : waitc;
      if (mv && rdy && er != 0) q.push_back('{er, ed, alu && er == ar});
      exp_stall = waitc >= MAX_WAIT;
    end
    #1;
    check("we", 64'(wb.ctrl_writeEnable), 64'(exp_we));
    if (exp_we) check("wr_addr_data", {wb.ctrl_writeReg, wb.data_writeReg}, {exp_rd, exp_data});
    check("stall", 64'(wb.wb_stall), 64'(exp_stall));
    check("pend", 64'(wb.pend_count), 64'(q.size()));
  endtask
  initial begin
    repeat (2) cyc(1, 0, 0, 0, 0, 0, 0, 0);
    check("rst_outs", {wb.ctrl_writeEnable, wb.ctrl_writeReg, wb.data_writeReg, wb.wb_stall, wb.pend_count}, '0);
    cyc(0, 1, 5, 32'h1234, 0, 0, 0, 0);
    check("alu_r5", {wb.ctrl_writeEnable, wb.ctrl_writeReg, wb.data_writeReg}, {1'b1, 5'd5, 32'h1234});
    repeat (8) cyc(0, 1, 3, 32'h33, 1, 7, 32'hAA, 0);
    check("stall_hi", 64'(wb.wb_stall), 64'd1);
    check("full", 64'(wb.pend_count), 64'(DEPTH));
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    check("md_r7", {wb.ctrl_writeEnable, wb.ctrl_writeReg, wb.data_writeReg, wb.wb_stall}, {1'b1, 5'd7, 32'hAA, 1'b0});
    repeat (3) cyc(0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 9, 32'h11, 0);
    cyc(0, 1, 9, 32'h22, 0, 0, 0, 0);
    check("alu_r9", {wb.ctrl_writeEnable, wb.ctrl_writeReg, wb.data_writeReg}, {1'b1, 5'd9, 32'h22});
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    check("killed_pop", {wb.ctrl_writeEnable, wb.pend_count}, '0);
    cyc(0, 1, 0, 32'h5, 1, 0, 32'h6, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    check("r0_none", {wb.ctrl_writeEnable, wb.pend_count}, '0);
    cyc(0, 0, 0, 0, 1, 4, 32'h55, 1);
    repeat (2) cyc(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) cyc(0, 1, 2, 32'h77, 1, 6, 32'h66, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    check("rst_mid", {wb.ctrl_writeEnable, wb.ctrl_writeReg, wb.data_writeReg, wb.wb_stall, wb.pend_count}, '0);
    repeat (4) cyc(0, 0, 0, 0, 0, 0, 0, 0);
    for (int n = 0; n < 2000; n++) begin
      automatic bit r = $urandom_range(0, 99) == 0;
      automatic bit av = $urandom_range(0, 99) < (exp_stall ? 10 : 55);
      cyc(r, av, 5'($urandom_range(0, 7)), $urandom, $urandom_range(0, 1) == 1,
          5'($urandom_range(0, 7)), $urandom, $urandom_range(0, 3) == 0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Shares the register file's single write port between two writeback sources: the in-order ALU pipeline and the multi-cycle multiply/divide unit. ALU writebacks always win the port. Multdiv results wait in a small pending FIFO until the port is free. The block also enforces $r0 immutability, preserves write-after-write ordering between the two sources, and guards the FIFO against starvation with a stall request. It sits directly in front of the register file's ctrl_writeEnable / ctrl_writeReg / data_writeReg inputs.

## Interface
Parameters:
- DEPTH, 2: number of pending-FIFO entries (1..4).
- MAX_WAIT, 4: consecutive cycles the FIFO head may go ungranted before wb_stall is raised (1..15).

Ports:
- clock  in  1  single clock; all state updates on the rising edge.
- ctrl_reset  in  1  synchronous, active-high reset.
- alu_wb_valid  in  1  ALU writeback request this cycle; always accepted, no ready.
- alu_wb_reg  in  5  ALU destination register.
- alu_wb_data  in  32  ALU result.
- md_wb_valid  in  1  multdiv result valid.
- md_wb_ready  out  1  FIFO can accept; a transfer happens when md_wb_valid && md_wb_ready.
- md_wb_reg  in  5  multdiv destination register.
- md_wb_data  in  32  multdiv result.
- md_wb_exc  in  1  multdiv exception flag (used only with MD_EXC_EN).
- ctrl_writeEnable  out  1  registered write enable to the register file.
- ctrl_writeReg  out  5  registered write address.
- data_writeReg  out  32  registered write data.
- wb_stall  out  1  registered request that upstream hold alu_wb_valid low next cycle.
- pend_count  out  3  current FIFO occupancy.

## Operation
- **Grant each cycle.**
  - If alu_wb_valid && alu_wb_reg != 0: grant ALU.
  - Else, if the FIFO head is live: grant the head and pop it.
  - Else, if the head is killed: pop it silently, with no port write.
  - Else: no write.
- **$r0 writes.** A write to $r0 from either source is never issued.
  - An ALU write to $r0 counts as no request.
  - A multdiv write to $r0 is accepted (handshake completes) but is not enqueued.
- **Kill on ALU grant (WAW ordering).** Every FIFO entry with reg == alu_wb_reg gets its kill bit set. This covers an entry being pushed in the same cycle. Rationale: the multdiv result is older and must not overwrite the newer ALU value.
- **md_wb_ready.** Equals pend_count < DEPTH. It is driven from registered state only. A pop in the current cycle does not raise ready that same cycle.
- **Simultaneous push and pop.** Both occur; occupancy is unchanged.
- **Starvation.**
  - wait_cnt increments in each cycle where the head is live and not granted.
  - It clears on a head grant or when the FIFO is empty.
  - wb_stall is registered: it is 1 in the cycle after wait_cnt reaches MAX_WAIT, and stays 1 until the head is granted.
- **Stall protocol violation.** Upstream must drive alu_wb_valid low while wb_stall is 1. If alu_wb_valid is high anyway, the ALU still wins (no ALU write is ever dropped) and wb_stall stays high.
- **Reset.** All FIFO entries are discarded, including reset in the middle of a pending entry.

## Timing
- ALU request in cycle N: the port write appears in cycle N+1.
- Multdiv push in cycle N: the earliest port write is in cycle N+2 (enqueue, then head grant).
- Reset values: ctrl_writeEnable 0, ctrl_writeReg 0, data_writeReg 0, wb_stall 0, pend_count 0. md_wb_ready is 1 in the first cycle after reset deasserts.
- While ctrl_reset is high:
  - md_wb_ready is 0.
  - No push occurs.
  - wait_cnt is 0.
- Pointers wrap modulo DEPTH.
- pend_count never exceeds DEPTH.

## Configuration
- **MD_EXC_EN defined.** A pushed entry with md_wb_exc=1 is redirected: reg becomes 30 ($rstatus), data becomes {31'b0, 1'b1}. The kill comparison uses the redirected register.
- **MD_EXC_EN undefined.** md_wb_exc is ignored, and entries keep md_wb_reg/md_wb_data unchanged.

## Structure
- Package regfile_ctrl_pkg holds:
  - REG_ZERO = 5'd0 and REG_RSTATUS = 5'd30.
  - The exception data constant.
  - typedef wb_entry_t {reg[4:0], data[31:0], kill}.
- Sub-module wb_pend_fifo holds the DEPTH-entry circular buffer and its head/tail/count logic.
  - Besides normal push/pop, it has a parallel kill-by-address input.
  - The arbiter owns grant, $r0 filtering, starvation, and the output registers.

## Test plan
- ALU write r5=0x1234 in cycle N, with no multdiv traffic → ctrl_writeEnable=1, ctrl_writeReg=5, data_writeReg=0x1234 in N+1.
- ALU write r3 every cycle while multdiv pushes r7=0xAA → md_wb_ready=0 after DEPTH pushes. With MAX_WAIT=4, wb_stall=1 after 4 ungranted cycles. Once the bench drops alu_wb_valid, r7=0xAA is written the next cycle and wb_stall returns to 0.
- Multdiv pushes r9=0x11, then the ALU writes r9=0x22 while the entry is still pending → the port writes only r9=0x22. The killed entry pops with no write, and pend_count returns to 0.
- Multdiv write to r0, and ALU write to r0 → the handshake completes, ctrl_writeEnable stays 0, pend_count stays 0.
- With MD_EXC_EN defined, a multdiv push of r4 with md_wb_exc=1 → the port writes r30=0x00000001. With MD_EXC_EN undefined, the port writes r4 with md_wb_data.
- Assert ctrl_reset while the FIFO holds 2 entries → the next cycle has all outputs at 0 and pend_count=0. No stale entry is ever written after reset.
